// File: rtl/pkt_byte_tx_pkg.sv
// Shared types and sizing helpers for the packet-to-byte serializer.
// Contents: FSM state enumeration (CSUM state exists only when
// PKT_BYTE_TX_CSUM_EN is defined), byte-count and index-width helpers.
package pkt_byte_tx_pkg;

`ifdef PKT_BYTE_TX_CSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_CSUM  = 3'd4
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SEND  = 2'd3
    } state_e;
`endif

    // Number of whole bytes carried in one packet payload.
    function automatic int unsigned calc_nbytes(input int unsigned data_w,
                                                input int unsigned byte_w);
        return data_w / byte_w;
    endfunction

    // Bits needed to index 0..nbytes-1 (at least one bit).
    function automatic int unsigned idx_width(input int unsigned nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/pkt_byte_tx_csum_acc.sv
// Running XOR of transmitted data bytes; present only when
// PKT_BYTE_TX_CSUM_EN is defined.
// Ports: clk, rst_n (async active-low), clr (zero the sum), en (fold
// byte_in into the sum), byte_in, csum (registered running XOR).
`ifdef PKT_BYTE_TX_CSUM_EN
module pkt_csum_acc #(
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    output logic [BYTE_WIDTH-1:0] csum
);

    // Accumulator register; clear wins over accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (clr) begin
            csum <= '0;
        end else if (en) begin
            csum <= csum ^ byte_in;
        end
    end

endmodule
`endif

// File: rtl/pkt_byte_tx.sv
// Pops one {len, data} packet from an upstream FIFO and streams len+1
// payload bytes (saturated to NBYTES) to a UART over a valid/ready handshake.
// Optional macro PKT_BYTE_TX_CSUM_EN appends an XOR checksum byte.
// Ports: clk, rst_n (async active-low), fifo_empty/fifo_rd_en/fifo_dout
// (FIFO side, data valid the cycle after the read strobe), tx_ready/
// tx_valid/tx_data (UART side), busy (not IDLE), pkt_done (packet finished).
module pkt_byte_tx
    import pkt_byte_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 48,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 3,
    parameter int unsigned MSB_FIRST  = 0,
    localparam int unsigned PACKET_WIDTH = LEN_WIDTH + DATA_WIDTH,
    localparam int unsigned NBYTES       = calc_nbytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic [PACKET_WIDTH-1:0] fifo_dout,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [BYTE_WIDTH-1:0]   tx_data,
    output logic                    busy,
    output logic                    pkt_done
);

    localparam int unsigned IDX_W = idx_width(NBYTES);

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]      last_q, last_d;   // count-1 of the current packet
    logic [IDX_W-1:0]      cnt_q,  cnt_d;    // bytes already accepted
    logic                  tx_valid_q, tx_valid_d;
    logic [BYTE_WIDTH-1:0] tx_data_q,  tx_data_d;
    logic                  rd_en_q,    rd_en_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;

    logic [LEN_WIDTH-1:0]  in_len;
    logic [DATA_WIDTH-1:0] in_data;
    logic [IDX_W-1:0]      in_last;
    logic                  handshake;
    logic                  last_hit;

    // Map transmit position to payload byte index for the configured order.
    function automatic logic [IDX_W-1:0] pos_to_idx(input logic [IDX_W-1:0] pos,
                                                    input logic [IDX_W-1:0] last);
        if (MSB_FIRST != 0) begin
            return last - pos;
        end
        return pos;
    endfunction

    function automatic logic [BYTE_WIDTH-1:0] get_byte(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [IDX_W-1:0]      idx);
        return d[32'(idx)*BYTE_WIDTH +: BYTE_WIDTH];
    endfunction

    // Decode the FIFO word; oversize lengths saturate to a full payload.
    assign in_len    = fifo_dout[PACKET_WIDTH-1 -: LEN_WIDTH];
    assign in_data   = fifo_dout[DATA_WIDTH-1:0];
    assign in_last   = (32'(in_len) >= NBYTES) ? IDX_W'(NBYTES - 1) : IDX_W'(in_len);
    assign handshake = tx_valid_q & tx_ready;
    assign last_hit  = (cnt_q == last_q);

`ifdef PKT_BYTE_TX_CSUM_EN
    logic [BYTE_WIDTH-1:0] csum_q;

    // Sum restarts on every new packet and folds in each accepted data byte.
    pkt_csum_acc #(
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_csum_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q == ST_LOAD),
        .en      (handshake && (state_q == ST_SEND)),
        .byte_in (tx_data_q),
        .csum    (csum_q)
    );
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SEND;
            ST_SEND: begin
                if (handshake && last_hit) begin
`ifdef PKT_BYTE_TX_CSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef PKT_BYTE_TX_CSUM_EN
            ST_CSUM:  if (handshake) state_d = ST_IDLE;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; everything is registered below.
    always_comb begin
        rd_en_d    = (state_d == ST_FETCH);
        busy_d     = (state_d != ST_IDLE);
        done_d     = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        data_d     = data_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_LOAD: begin
                data_d     = in_data;
                last_d     = in_last;
                cnt_d      = '0;
                tx_valid_d = 1'b1;
                tx_data_d  = get_byte(in_data, pos_to_idx('0, in_last));
            end
            ST_SEND: begin
                if (handshake) begin
                    if (last_hit) begin
                        cnt_d = '0;
`ifdef PKT_BYTE_TX_CSUM_EN
                        // Sum register lags by the byte being accepted now.
                        tx_data_d = csum_q ^ tx_data_q;
`else
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
`endif
                    end else begin
                        cnt_d     = cnt_q + IDX_W'(1);
                        tx_data_d = get_byte(data_q, pos_to_idx(cnt_q + IDX_W'(1), last_q));
                    end
                end
            end
`ifdef PKT_BYTE_TX_CSUM_EN
            ST_CSUM: begin
                if (handshake) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
`endif
            default: begin
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            data_q     <= data_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign pkt_done   = done_q;

endmodule

// File: tb/tb_pkt_byte_tx.sv
// Self-checking bench for pkt_byte_tx: instance 0 LSB-first, instance 1
// MSB-first, sharing a modelled FIFO and a UART ready driver.
module tb_pkt_byte_tx;

    localparam int unsigned PW = 51;
    localparam int unsigned NB = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    fifo_empty, fifo_rd_en, tx_valid, busy, pkt_done;
    logic [7:0]    tx_data [2];
    logic [PW-1:0] fifo_dout;
    logic          tx_ready = 1'b0;

    int errors = 0, checks = 0;
    int sel = 0, push_cnt = 0, pop_cnt = 0, reads = 0, done_cnt = 0, cyc = 0;
    int stab_err = 0, first_valid_cyc = 0, done_cyc = 0, stall_cnt = 0, rdy_pct = 100;
    logic [PW-1:0] fq[$];
    logic [7:0]    rx_q[$], exp_q[$];
    int            rx_cyc[$];
    bit            rd_pend = 1'b0, prev_v = 1'b0;
    bit            prev_stall [2];
    logic [7:0]    prev_data [2];

    pkt_byte_tx #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[0]), .fifo_rd_en(fifo_rd_en[0]),
        .fifo_dout(fifo_dout), .tx_ready(tx_ready), .tx_valid(tx_valid[0]),
        .tx_data(tx_data[0]), .busy(busy[0]), .pkt_done(pkt_done[0]));

    pkt_byte_tx #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty[1]), .fifo_rd_en(fifo_rd_en[1]),
        .fifo_dout(fifo_dout), .tx_ready(tx_ready), .tx_valid(tx_valid[1]),
        .tx_data(tx_data[1]), .busy(busy[1]), .pkt_done(pkt_done[1]));

    // Only the selected instance sees a non-empty FIFO.
    assign fifo_empty[0] = !(sel == 0 && push_cnt != pop_cnt);
    assign fifo_empty[1] = !(sel == 1 && push_cnt != pop_cnt);

    // FIFO model: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        cyc++;
        if (rd_pend && fq.size() > 0) begin
            fifo_dout <= fq.pop_front();
            pop_cnt++;
        end
    end

    // UART ready driver: forced stall count first, else random with rdy_pct.
    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            tx_ready = 1'b0;
            if (tx_valid[sel]) stall_cnt--;
        end else begin
            tx_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor on the falling edge: transfers, strobes, stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
            prev_v  = 1'b0;
            rd_pend = 1'b0;
        end else begin
            rd_pend = |fifo_rd_en;
            reads += int'(fifo_rd_en[0]) + int'(fifo_rd_en[1]);
            done_cnt += int'(pkt_done[0]) + int'(pkt_done[1]);
            if (pkt_done[sel]) done_cyc = cyc;
            if (tx_valid[sel] && !prev_v) first_valid_cyc = cyc;
            prev_v = tx_valid[sel];
            for (int i = 0; i < 2; i++) begin
                if (prev_stall[i] && (!tx_valid[i] || tx_data[i] != prev_data[i])) stab_err++;
                if (tx_valid[i] && tx_ready) begin
                    rx_q.push_back(tx_data[i]);
                    rx_cyc.push_back(cyc);
                end
                prev_stall[i] = tx_valid[i] && !tx_ready;
                prev_data[i]  = tx_data[i];
            end
        end
    end

    // Reference model: byte count = min(len+1, NB), chosen order, optional XOR.
    task automatic build_exp(input int len, input logic [47:0] data, input bit msb);
        int n, j;
        logic [7:0] b [NB];
        logic [7:0] x;
        n = (len + 1 > int'(NB)) ? int'(NB) : len + 1;
        x = 8'h00;
        for (int i = 0; i < int'(NB); i++) b[i] = 8'(data >> (8 * i));
        for (int k = 0; k < n; k++) begin
            j = msb ? n - 1 - k : k;
            exp_q.push_back(b[j]);
            x ^= b[j];
        end
`ifdef PKT_BYTE_TX_CSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic push_pkt(input int len, input logic [47:0] data);
        fq.push_back({3'(len), data});
        push_cnt++;
    endtask

    task automatic clear_obs();
        rx_q.delete();
        rx_cyc.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int count_bad();
        int nbad = 0;
        if (rx_q.size() != exp_q.size()) nbad++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) nbad++;
        return nbad;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({fifo_rd_en, tx_valid, busy, pkt_done} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000000", {fifo_rd_en, tx_valid, busy, pkt_done});
        end
        checks++;
        if (tx_data[0] !== 8'h00 || tx_data[1] !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h/%h want 00/00", tx_data[0], tx_data[1]);
        end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 2'b00 || reads != 0) begin
            errors++; $display("FAIL idle_empty: busy=%b reads=%0d want 00/0", busy, reads);
        end
    endtask

    task automatic test_basic();
        int p, d0;
        bit ok;
        sel = 0; rdy_pct = 100; clear_obs();
        repeat (2) @(posedge clk); #1;
        d0 = done_cnt;
        build_exp(5, 48'h665544332211, 1'b0);
        p = cyc;
        push_pkt(5, 48'h665544332211);
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: done_cnt=%0d want %0d", done_cnt, d0 + 1); end
        checks++;
        if (count_bad() != 0) begin
            errors++; $display("FAIL basic_bytes: got %p want %p", rx_q, exp_q);
        end
        checks++;
        if (first_valid_cyc - p != 3) begin
            errors++; $display("FAIL basic_latency: got %0d want 3", first_valid_cyc - p);
        end
        checks++;
        if (rx_cyc.size() == 0 || rx_cyc[rx_cyc.size()-1] - rx_cyc[0] != exp_q.size() - 1) begin
            errors++; $display("FAIL basic_b2b: span got %0d want %0d", rx_cyc.size() == 0 ? -1 : rx_cyc[rx_cyc.size()-1] - rx_cyc[0], exp_q.size() - 1);
        end
        checks++;
        if (rx_cyc.size() == 0 || done_cyc != rx_cyc[rx_cyc.size()-1] + 1) begin
            errors++; $display("FAIL basic_done_time: got %0d want last+1", done_cyc);
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (done_cnt != d0 + 1 || tx_valid !== 2'b00 || busy !== 2'b00) begin
            errors++; $display("FAIL basic_after: done=%0d valid=%b busy=%b want %0d/00/00", done_cnt, tx_valid, busy, d0 + 1);
        end
    endtask

    task automatic test_msb();
        int d0;
        bit ok;
        sel = 1; rdy_pct = 100; clear_obs();
        d0 = done_cnt;
        build_exp(2, 48'h000000CCBBAA, 1'b1);
        push_pkt(2, 48'h000000CCBBAA);
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || count_bad() != 0 || rx_q[0] !== 8'hCC) begin
            errors++; $display("FAIL msb_bytes: got %p want %p", rx_q, exp_q);
        end
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++; $display("FAIL msb_other_idle: busy0=%b want 0", busy[0]);
        end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int d0;
        bit ok;
        logic [47:0] d;
        sel = 0; rdy_pct = 100; clear_obs(); stab_err = 0;
        d0 = done_cnt;
        d = 48'({$urandom(), $urandom()});
        build_exp(1, d, 1'b0);
        stall_cnt = 4;
        push_pkt(1, d);
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || count_bad() != 0) begin
            errors++; $display("FAIL stall_bytes: got %p want %p", rx_q, exp_q);
        end
        checks++;
        if (stab_err != 0) begin
            errors++; $display("FAIL stall_stable: violations=%0d want 0", stab_err);
        end
        checks++;
        if (rx_cyc.size() == 0 || rx_cyc[0] - first_valid_cyc != 4) begin
            errors++; $display("FAIL stall_hold: got %0d want 4", rx_cyc.size() == 0 ? -1 : rx_cyc[0] - first_valid_cyc);
        end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        int d0;
        bit ok;
        logic [47:0] d;
        sel = 0; rdy_pct = 100; clear_obs();
        d0 = done_cnt;
        d = 48'({$urandom(), $urandom()});
        build_exp(7, d, 1'b0);
        push_pkt(7, d);
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || count_bad() != 0) begin
            errors++; $display("FAIL sat_bytes: got %0d bytes %p want %p", rx_q.size(), rx_q, exp_q);
        end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int d0, r0;
        bit ok;
        logic [47:0] d;
        int l;
        sel = 0; rdy_pct = 100; clear_obs();
        d0 = done_cnt; r0 = reads;
        for (int k = 0; k < 3; k++) begin
            d = 48'({$urandom(), $urandom()});
            l = $urandom_range(7);
            build_exp(l, d, 1'b0);
            push_pkt(l, d);
        end
        wait_done(d0 + 3, ok);
        checks++;
        if (!ok || count_bad() != 0) begin
            errors++; $display("FAIL b2b_bytes: got %p want %p", rx_q, exp_q);
        end
        checks++;
        if (reads - r0 != 3) begin
            errors++; $display("FAIL b2b_reads: got %0d want 3", reads - r0);
        end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_random();
        int d0, r0, l;
        bit ok;
        logic [47:0] d;
        rdy_pct = 50; r0 = reads;
        for (int k = 0; k < 24; k++) begin
            sel = int'($urandom_range(1)); clear_obs();
            d0 = done_cnt;
            d = 48'({$urandom(), $urandom()});
            l = $urandom_range(7);
            build_exp(l, d, sel == 1);
            push_pkt(l, d);
            wait_done(d0 + 1, ok);
            checks++;
            if (!ok || count_bad() != 0) begin
                errors++; $display("FAIL rand_pkt%0d: sel=%0d len=%0d got %p want %p", k, sel, l, rx_q, exp_q);
            end
            repeat (2) @(posedge clk); #1;
        end
        checks++;
        if (reads - r0 != 24) begin
            errors++; $display("FAIL rand_reads: got %0d want 24", reads - r0);
        end
        rdy_pct = 100;
    endtask

    task automatic test_reset_mid();
        int d0, r0;
        bit ok;
        sel = 0; rdy_pct = 100; clear_obs();
        r0 = reads;
        build_exp(5, 48'hA6A5A4A3A2A1, 1'b0);
        push_pkt(5, 48'hA6A5A4A3A2A1);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (rx_q.size() >= 2) break;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 2'b00 || busy !== 2'b00 || tx_data[0] !== 8'h00) begin
            errors++; $display("FAIL rstmid_now: valid=%b busy=%b data=%h want 00/00/00", tx_valid, busy, tx_data[0]);
        end
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'hA1 || rx_q[1] !== 8'hA2 || reads - r0 != 1 || busy !== 2'b00) begin
            errors++; $display("FAIL rstmid_discard: rx=%p reads=%0d busy=%b want A1,A2/1/00", rx_q, reads - r0, busy);
        end
        clear_obs();
        d0 = done_cnt;
        build_exp(5, 48'h0F0E0D0C0B0A, 1'b0);
        push_pkt(5, 48'h0F0E0D0C0B0A);
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || count_bad() != 0 || reads - r0 != 2) begin
            errors++; $display("FAIL rstmid_next: got %p want %p reads=%0d want 2", rx_q, exp_q, reads - r0);
        end
        repeat (2) @(posedge clk); #1;
    endtask

`ifdef PKT_BYTE_TX_CSUM_EN
    task automatic test_csum();
        int d0;
        bit ok;
        sel = 0; rdy_pct = 100; clear_obs();
        d0 = done_cnt;
        build_exp(2, 48'h000000040201, 1'b0);
        push_pkt(2, 48'h000000040201);
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || rx_q.size() != 4 || rx_q[3] !== 8'h07 || count_bad() != 0) begin
            errors++; $display("FAIL csum_byte: got %p want 01,02,04,07", rx_q);
        end
        repeat (2) @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_msb();
        test_backpressure();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef PKT_BYTE_TX_CSUM_EN
        test_csum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
